if_pc_gen: RTL

Instruction-fetch front stage. It owns the architectural fetch PC and issues requests on the SRAM-style instruction bus. It presents fetched instructions to the IF/ID register through a valid/ready handshake. It consumes the IF-stage flush bit (flush[4]) and flush_pc from the pipeline controller to redirect fetch, dropping any response already in flight.

---
 rtl/if_pc_gen_if.sv | 31 +++
 rtl/if_pc_gen.sv | 128 ++++++++++++
 2 files changed

// File: rtl/if_pc_gen_if.sv
// Fetch-stage bundle: SRAM-style instruction bus plus the IF/ID valid/ready handshake.
// The master side is the PC generator; the slave side is the memory and the IF/ID register.
interface if_pc_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  inst_req;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic                  inst_addr_ok;
  logic                  inst_data_ok;
  logic [DATA_WIDTH-1:0] inst_rdata;
  logic                  if_valid;
  logic                  if_ready;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [DATA_WIDTH-1:0] if_inst;
  logic                  if_adef;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output if_valid, if_pc, if_inst, if_adef,
    input  if_ready
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  if_valid, if_pc, if_inst, if_adef,
    output if_ready
  );
endinterface

// File: rtl/if_pc_gen.sv
// Instruction-fetch PC generator: one outstanding bus transaction, redirect on flush,
// and a drop flag that swallows the response of a request orphaned by a redirect.
module if_pc_gen #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h1c000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_if,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  if_pc_gen_if.master           bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  drop_q;
  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] if_pc_q;
  logic [DATA_WIDTH-1:0] if_inst_q;
  logic                  if_adef_q;

  logic                  misaligned;
  logic                  req_fire;
  logic [ADDR_WIDTH-1:0] pc_d;

  function automatic logic [ADDR_WIDTH-1:0] pc_next(input logic [ADDR_WIDTH-1:0] pc);
    return pc + ADDR_WIDTH'(4);
  endfunction

  assign misaligned = (pc_q[1:0] != 2'b00);
  assign pc_d       = pc_next(pc_q);

  // Request is derived from registered state only; reset holds it low immediately.
  assign bus.inst_req  = !rst && (state_q == S_REQ) && !misaligned;
  assign bus.inst_addr = pc_q;
  assign req_fire      = bus.inst_req && bus.inst_addr_ok;

  assign bus.if_valid = valid_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.if_inst  = if_inst_q;
  assign bus.if_adef  = if_adef_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      valid_q   <= 1'b0;
      if_pc_q   <= '0;
      if_inst_q <= '0;
      if_adef_q <= 1'b0;
    end else if (flush_if) begin
      pc_q <= flush_pc;
      case (state_q)
        S_REQ: begin
          // A request accepted this very cycle is already in flight and must be swallowed.
          if (req_fire) begin
            drop_q  <= 1'b1;
            state_q <= S_WAIT;
          end else begin
            state_q <= S_REQ;
          end
        end
        S_WAIT: begin
          if (bus.inst_data_ok) begin
            drop_q  <= 1'b0;
            state_q <= S_REQ;
          end else begin
            drop_q  <= 1'b1;
          end
        end
        S_HOLD: begin
          valid_q <= 1'b0;
          state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (misaligned) begin
            if_pc_q   <= pc_q;
            if_inst_q <= '0;
            if_adef_q <= 1'b1;
            valid_q   <= 1'b1;
            state_q   <= S_HOLD;
          end else if (req_fire) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.inst_data_ok) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              if_inst_q <= bus.inst_rdata;
              if_pc_q   <= pc_q;
              if_adef_q <= 1'b0;
              valid_q   <= 1'b1;
              pc_q      <= pc_d;
              state_q   <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // A faulting PC was never advanced, so it re-faults until redirected.
          if (bus.if_ready) begin
            valid_q <= 1'b0;
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  a_rsp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    bus.inst_data_ok |-> (state_q == S_WAIT));

endmodule
